// File: rtl/temporal_mac_array.sv
// temporal_mac_array: DIM_A x DIM_C products by counter-sweep accumulation, start/busy/done handshake.
// Optional TLUT_ACC_SATURATE_EN: accumulators saturate instead of wrapping.
module temporal_mac_array #(
  parameter int DIM_A        = 8,
  parameter int DIM_C        = 1,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 12
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  logic                                          start,
  input  logic                                          acc_en,
  input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]             in,
  input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]            weight,
  output logic                                          busy,
  output logic                                          done,
  output logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [INPUT_WIDTH-1:0] LAST = {{(INPUT_WIDTH-1){1'b1}}, 1'b0};
  state_t state, state_nx;
  logic [INPUT_WIDTH-1:0] cnt;
  logic [DIM_A-1:0][INPUT_WIDTH-1:0] in_q;
  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] w_q;
  logic accept;
  function automatic logic [ACC_WIDTH-1:0] add_w(input logic [ACC_WIDTH-1:0] a, input logic [WEIGHT_WIDTH-1:0] w);
`ifdef TLUT_ACC_SATURATE_EN
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH+1)'(w);
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
    return a + ACC_WIDTH'(w);
`endif
  endfunction
  assign accept = enable && start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    if (enable)
      state_nx = accept ? RUN : state == RUN ? (cnt == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Each cell sees one add of w_q[c] per sweep step while cnt is below its input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      in_q <= '0;
      w_q  <= '0;
      out  <= '0;
    end else if (accept) begin
      cnt  <= '0;
      in_q <= in;
      w_q  <= weight;
      if (!acc_en) out <= '0;
    end else if (enable && state == RUN) begin
      cnt <= cnt + INPUT_WIDTH'(1);
      for (int c = 0; c < DIM_C; c++)
        for (int a = 0; a < DIM_A; a++)
          if (cnt < in_q[a]) out[c][a] <= add_w(out[c][a], w_q[c]);
    end
endmodule

// File: doc/temporal_mac_array.md
# temporal_mac_array

Parametrised successor to the baseline multiplier array. It computes every product `in[a] * weight[c]` for a DIM_A × DIM_C grid by temporal (counter-sweep) multiplication rather than parallel multipliers. It adds a start/busy/done handshake, optional accumulation across back-to-back operations, and a global stall. It sits between the input/weight staging registers and the output LUT/requantisation stage.

## Interface
- `DIM_A`, 8, number of input lanes
- `DIM_C`, 1, number of weight channels
- `INPUT_WIDTH`, 4, unsigned input width; sets sweep length N = 2^INPUT_WIDTH − 1
- `WEIGHT_WIDTH`, 8, unsigned weight width
- `ACC_WIDTH`, 12, per-cell accumulator width; must be ≥ INPUT_WIDTH + WEIGHT_WIDTH

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  global advance; when 0, all state, counter and accumulators hold
- `start`  in  1  request a new operation
- `acc_en`  in  1  sampled with `start`: 1 = add to existing `out`, 0 = clear first
- `in`  in  [DIM_A-1:0][INPUT_WIDTH-1:0]  input lanes; lane a is `in[a]`
- `weight`  in  [DIM_C-1:0][WEIGHT_WIDTH-1:0]  channel weights
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `out`  out  [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]  accumulators; `out[c][a]` accumulates `in[a]*weight[c]`

## Operation
- States: IDLE, RUN, DONE.
- Reset value of every output is 0. This applies to `busy`, `done` and all `out` cells, and the state is IDLE.
- An accept is an enabled edge with `start`=1 in IDLE or DONE. On accept:
  - latch `in` → in_q and `weight` → w_q;
  - set the sweep counter cnt to 0;
  - clear all accumulators if `acc_en`=0;
  - go to RUN.
- `start` in RUN is ignored, and no error is raised.
- RUN, on each enabled edge:
  - every cell with cnt < in_q[a] does acc[c][a] += w_q[c];
  - cnt increments;
  - the edge with cnt = N−1 performs its add and moves to DONE.
- DONE: `out` holds the final result. An enabled edge without `start` goes to IDLE, and `out` stays held. An enabled edge with `start` is an accept (back-to-back operation).
- After one operation with `acc_en`=0, `out[c][a]` = in_q[a] × w_q[c] exactly. An input of 0 gives 0.
- Inputs `in`/`weight` may change freely after accept without affecting the operation.
- Overflow behaviour is set by the configuration below. A single operation can never overflow, given the ACC_WIDTH rule.

## Timing
- The accept edge is edge 0. RUN covers edges 1..N. `busy`=1 from after edge 0 until after edge N.
- `done` rises after edge N and is registered (state decode, no combinational path from inputs).
- For the default widths, N = 15, and `done` is first high in the cycle after the 15th RUN edge.
- `enable`=0 stretches latency by one cycle per low cycle. It freezes cnt, state, `busy`, `done` and `out`.
- `rst_n` low at any time, including mid-RUN: all registers go to 0 and the state to IDLE immediately (asynchronously). The first accept is possible on the first enabled edge after release.
- Back-to-back: with `start` held high from DONE, the next RUN begins with no IDLE cycle. The period is N+1 cycles.

## Configuration
- `TLUT_ACC_SATURATE_EN` defined: each add saturates at 2^ACC_WIDTH − 1, and the cell stays saturated until it is cleared.
- `TLUT_ACC_SATURATE_EN` undefined: adds wrap modulo 2^ACC_WIDTH.

## Test plan
- Identity check (defaults):
  - stimulus: `in` = {8,9,10,11,12,13,14,15} (lane 7 → lane 0), `weight` = 1, `acc_en`=0, start;
  - response: `done` after 16 cycles, and `out[0][a]` = `in[a]` (lane 0 = 15, lane 7 = 8).
- Maximum single product:
  - stimulus: `in`=15 on all lanes, `weight`=255;
  - response: all `out` = 3825, and `busy` high for exactly 15 cycles.
- Accumulate overflow:
  - stimulus: the maximum-product operation, then a back-to-back start with `acc_en`=1;
  - response: `out` = 3554 (wrap) without the macro, and 4095 with `TLUT_ACC_SATURATE_EN`.
- Stall:
  - stimulus: drop `enable` for 5 cycles mid-RUN;
  - response: cnt/`out` frozen, and `done` arrives 21 cycles after accept with correct products.
- Start ignored while busy:
  - stimulus: pulse `start` with different `in` during RUN;
  - response: the result matches the original operands, and `done` timing is unchanged.
- Reset mid-RUN:
  - stimulus: assert `rst_n`=0 at sweep step 7;
  - response: `out`, `busy` and `done` go to 0 immediately. A fresh operation after release produces correct products.
